// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core types: SIMD remote store request, sequencer states, credit default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   bsg_vanilla_max_out_credits_gp : default endpoint outstanding-request limit
//   simd_remote_store_s            : one 4-word SIMD store (addr, data[4], mask[4]) at default widths
//   lsu_simd_seq_state_e           : sequencer FSM states
package bsg_vanilla_pkg;

  localparam int bsg_vanilla_max_out_credits_gp = 16;
  localparam int simd_words_gp                  = 4;
  localparam int simd_data_width_gp             = 32;
  localparam int simd_addr_width_gp             = 32;
  localparam int simd_mask_width_gp             = simd_data_width_gp >> 3;

  typedef struct packed {
    logic [simd_addr_width_gp-1:0]                     addr;
    logic [simd_words_gp-1:0][simd_data_width_gp-1:0]  data;
    logic [simd_words_gp-1:0][simd_mask_width_gp-1:0]  mask;
  } simd_remote_store_s;

  typedef enum logic [1:0] {
    e_seq_idle = 2'd0,
    e_seq_send = 2'd1,
    e_seq_done = 2'd2
  } lsu_simd_seq_state_e;

endpackage

// File: rtl/bsg_counter_up_down.sv
// Saturating up/down counter used for outstanding-request credits.
// Latency: count visible one cycle after up/down.
// Backpressure: none; up and down in the same cycle cancel.
//
// Ports:
//   clk_i, reset_i (sync, active-low) : clock and reset (reset loads init_val_p)
//   up_i / down_i                      : increment / decrement request
//   count_o                            : registered count
module bsg_counter_up_down #(
  parameter  int max_val_p  = 16,
  parameter  int init_val_p = 16,
  localparam int ptr_width_lp = $clog2(max_val_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    up_i,
  input  logic                    down_i,
  output logic [ptr_width_lp-1:0] count_o
);

  localparam logic [ptr_width_lp-1:0] max_lp = ptr_width_lp'(max_val_p);

  logic [ptr_width_lp-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (up_i && !down_i) begin
      // A return at max is a protocol error; hold the count rather than wrap.
      count_d = (count_q == max_lp) ? count_q : count_q + 1'b1;
    end else if (down_i && !up_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      count_q <= ptr_width_lp'(init_val_p);
    end else begin
      count_q <= count_d;
      assert (!(up_i && !down_i && count_q == max_lp))
        else $error("bsg_counter_up_down: increment at max value");
      assert (!(down_i && !up_i && count_q == '0))
        else $error("bsg_counter_up_down: decrement at zero");
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_priority_encode.sv
// Lowest-set-bit priority encoder.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_i    : request vector
//   addr_o : index of the lowest set bit (0 when none set)
//   v_o    : any bit set
module bsg_priority_encode #(
  parameter  int width_p = 4,
  localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic [width_p-1:0]     i_i,
  output logic [lg_width_lp-1:0] addr_o,
  output logic                   v_o
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    addr_o = '0;
    for (int k = width_p - 1; k >= 0; k--) begin
      if (i_i[k]) addr_o = lg_width_lp'(k);
    end
  end

  assign v_o = |i_i;

endmodule

// File: rtl/lsu_simd_remote_sequencer.sv
// Splits one 4-word SIMD store into single-word remote store packets, skipping zero-mask words.
// Latency: accept at N, first packet offered at N+1, done_o one cycle after the last send.
// Backpressure: holds the packet on !remote_ready_i; withholds remote_v_o at zero credits; ready_o=0 while busy.
//
// Ports:
//   clk_i, reset_i (sync, active-low)          : clock / reset
//   v_i, ready_o, addr_i, data_i, mask_i       : SIMD store request from the LSU
//   remote_v_o/_addr_o/_data_o/_mask_o, remote_ready_i : single-word packet to network TX
//   credit_return_i, credits_o                 : endpoint credit return / available credits
//   busy_o, done_o                             : request in progress / completion pulse
module lsu_simd_remote_sequencer
  import bsg_vanilla_pkg::*;
#(
  parameter  int data_width_p       = 32,
  parameter  int addr_width_p       = 32,
  parameter  int max_out_credits_p  = bsg_vanilla_max_out_credits_gp,
  localparam int data_mask_width_lp = data_width_p >> 3,
  localparam int credit_width_lp    = $clog2(max_out_credits_p + 1)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                v_i,
  output logic                                ready_o,
  input  logic [addr_width_p-1:0]             addr_i,
  input  logic [3:0][data_width_p-1:0]        data_i,
  input  logic [3:0][data_mask_width_lp-1:0]  mask_i,
  output logic                                remote_v_o,
  output logic [addr_width_p-1:0]             remote_addr_o,
  output logic [data_width_p-1:0]             remote_data_o,
  output logic [data_mask_width_lp-1:0]       remote_mask_o,
  input  logic                                remote_ready_i,
  input  logic                                credit_return_i,
  output logic [credit_width_lp-1:0]          credits_o,
  output logic                                busy_o,
  output logic                                done_o
);

  lsu_simd_seq_state_e                state_q;
  logic [3:0]                         pending_q, pending_d;
  logic [addr_width_p-1:0]            base_q;
  logic [3:0][data_width_p-1:0]       data_q;
  logic [3:0][data_mask_width_lp-1:0] mask_q;
  logic [3:0]                         req_pending;
  logic [1:0]                         idx;
  logic                               pend_v;
  logic [credit_width_lp-1:0]         credits;
  logic                               accept, send;

  bsg_priority_encode #(.width_p(4)) pe (
    .i_i   (pending_q),
    .addr_o(idx),
    .v_o   (pend_v)
  );

  bsg_counter_up_down #(
    .max_val_p (max_out_credits_p),
    .init_val_p(max_out_credits_p)
  ) credit_ctr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .up_i   (credit_return_i),
    .down_i (send),
    .count_o(credits)
  );

  always_comb begin
    for (int k = 0; k < 4; k++) req_pending[k] = |mask_i[k];
  end

  // Valid comes only from registered state and count, never from remote_ready_i.
  assign remote_v_o    = (state_q == e_seq_send) && pend_v && (credits != '0);
  assign send          = remote_v_o && remote_ready_i;
  assign accept        = v_i && ready_o;
  assign pending_d     = pending_q & ~(4'b0001 << idx);
  assign remote_addr_o = base_q + addr_width_p'({idx, 2'b00});
  assign remote_data_o = data_q[idx];
  assign remote_mask_o = mask_q[idx];

  assign ready_o   = (state_q == e_seq_idle);
  assign busy_o    = (state_q != e_seq_idle);
  assign done_o    = (state_q == e_seq_done);
  assign credits_o = credits;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= e_seq_idle;
      pending_q <= '0;
    end else begin
      unique case (state_q)
        e_seq_idle: if (accept) begin
          pending_q <= req_pending;
          state_q   <= (|req_pending) ? e_seq_send : e_seq_done;
        end
        e_seq_send: if (send) begin
          pending_q <= pending_d;
          if (pending_d == '0) state_q <= e_seq_done;
        end
        e_seq_done: state_q <= e_seq_idle;
        default:    state_q <= e_seq_idle;
      endcase
    end
  end

  // Request payload needs no reset: it is only observed while pending bits are set.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      base_q <= addr_i & ~addr_width_p'(3);
      data_q <= data_i;
      mask_q <= mask_i;
    end
  end

endmodule

// File: doc/lsu_simd_remote_sequencer.md
# lsu_simd_remote_sequencer

Sequences one 4-word SIMD store from the load/store unit into up to four single-word remote store packets on the network TX interface. Words with an all-zero byte mask are skipped. An outstanding-request credit counter enforces the endpoint credit limit. The block sits between the LSU's EXE-stage request output and the network TX link, and holds the core's SIMD store until all words have issued.

## Interface
Parameters:
- data_width_p, 32, word width in bits; data_mask_width_lp = data_width_p>>3.
- addr_width_p, 32, remote address width.
- max_out_credits_p, 16, endpoint outstanding-request limit; credit_width_lp = clog2(max_out_credits_p+1).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; synchronous, active-low.
- v_i  in  1  SIMD store request valid.
- ready_o  out  1  block can accept a request.
- addr_i  in  addr_width_p  word-0 byte address; bits [1:0] are ignored and treated as 0.
- data_i  in  4 x data_width_p  store data for word 0..3.
- mask_i  in  4 x data_mask_width_lp  per-word byte masks.
- remote_v_o  out  1  remote store packet valid.
- remote_addr_o  out  addr_width_p  packet byte address.
- remote_data_o  out  data_width_p  packet data.
- remote_mask_o  out  data_mask_width_lp  packet byte mask.
- remote_ready_i  in  1  network TX accepts the packet.
- credit_return_i  in  1  one returned credit this cycle.
- credits_o  out  credit_width_lp  credits currently available.
- busy_o  out  1  a request is in progress (not IDLE).
- done_o  out  1  single-cycle pulse when a request completes.

## Operation
State machine: IDLE, SEND, DONE.

**Reset** (reset_i=0 at a clock edge):
- State goes to IDLE.
- Pending vector is cleared.
- Credit count is set to max_out_credits_p.
- Output values during/after reset: ready_o=1, remote_v_o=0, busy_o=0, done_o=0, credits_o=max_out_credits_p.
- Reset asserted mid-operation abandons the in-progress request, including words not yet sent. No done_o pulse is produced.

**IDLE**
- ready_o=1.
- On v_i & ready_o, latch addr_i (with [1:0] forced to 0), data_i and mask_i.
- Set pending[k] = |mask_i[k] for each word k.
- If pending != 0, go to SEND; otherwise go to DONE.

**SEND**
- ready_o=0.
- idx = lowest set bit of pending.
- Packet fields:
  - remote_addr_o = base + (idx<<2), arithmetic modulo 2^addr_width_p.
  - remote_data_o = data[idx].
  - remote_mask_o = mask[idx].
- remote_v_o = (credits != 0). Output fields are driven from registers plus the encoder and are stable while remote_v_o is held.
- A packet is sent on remote_v_o & remote_ready_i. A send clears pending[idx] and consumes one credit.
- If the send clears the last pending bit, go to DONE.
- Skipped (zero-mask) words cost no cycles.

**DONE**
- done_o=1 for this one cycle; ready_o=0.
- Next state is IDLE.

**Credit counter**
- Decrement on a send; increment on credit_return_i.
- Send and return in the same cycle leave the count unchanged.
- A return while the count is at max saturates the count and fires a simulation error.
- A send with 0 credits cannot occur, because remote_v_o is gated by credits != 0.

**Other rules**
- remote_v_o never depends combinationally on remote_ready_i.
- v_i while not ready is ignored; the upstream stage holds its request.

## Timing
- Accept at cycle N → first remote_v_o at N+1.
- With full credits and remote_ready_i held high, k non-empty words issue in cycles N+1..N+k. DONE occurs at N+k+1; IDLE and accept are possible again at N+k+2.
- A request with all masks zero: DONE at N+1, IDLE at N+2.
- credits_o reflects the registered count; a return at cycle t is visible at t+1 and can enable a send at t+1.

## Structure
- Shared package bsg_vanilla_pkg gains:
  - the SIMD remote store request struct (addr, data[4], mask[4]);
  - a constant for the default credit limit.
- Credit counter: instantiate bsg_counter_up_down (max_val max_out_credits_p, init max_out_credits_p).
- Word selection: bsg_priority_encode on pending.
- FSM and latched-request registers are local to this module.

## Test plan
- **Full store, full credits:** addr_i=0x1002, all masks 0xF, remote_ready_i=1 → packets at 0x1000, 0x1004, 0x1008, 0x100C in four consecutive cycles; done_o on the fifth cycle after accept; credits_o ends at 12.
- **Sparse mask:** masks {0x0,0x3,0x0,0x8} → exactly two packets: 0x1004 mask 0x3, then 0x100C mask 0x8, back-to-back; all-zero masks → no packet, done_o at N+1.
- **Credit stall:** max_out_credits_p=16, drain credits to 1, then issue a 4-word store → one packet, remote_v_o=0 until credit_return_i pulses, then one packet per returned credit.
- **Backpressure:** remote_ready_i low for 3 cycles on word 1 → addr, data and mask held stable, no credit consumed, word order preserved.
- **Simultaneous events:** send and credit_return_i in the same cycle → credits_o unchanged; credit_return_i at max → count stays 16 and a simulation error fires.
- **Reset mid-request:** reset_i=0 after the second packet → no further packets, no done_o, credits_o=16, ready_o=1 next cycle.
